// File: rtl/huffman_encoder_packer.sv
// Huffman-encodes signed 4-bit samples and packs the codewords into
// 1-4 bit chunks (oldest bit in the chunk MSB); flush drains the tail.
// Ports: clk, reset_n | sym_valid, sym_data, sym_ready (sample in)
//        flush, flush_done (drain request / completion pulse)
//        out_valid, out_data, out_len, out_ready (chunk out) | bit_count
module huffman_encoder_packer #(
  parameter int MAX_CODE = 9,
  parameter int BUF_W    = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sym_valid,
  input  logic [3:0] sym_data,
  output logic       sym_ready,
  input  logic       flush,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic [2:0] out_len,
  input  logic       out_ready,
  output logic       flush_done,
  output logic [3:0] bit_count
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state;
  logic [BUF_W-1:0] bit_buf;
  logic flush_pend;

  logic [MAX_CODE-1:0] code;
  logic [3:0] code_len;

  always_comb begin
    code = '0;
    code_len = 4'd1;
    unique case (sym_data)
      4'h0: begin code = 9'b000000000; code_len = 4'd1; end
      4'h1: begin code = 9'b000000100; code_len = 4'd3; end
      4'hD: begin code = 9'b000001010; code_len = 4'd4; end
      4'h2: begin code = 9'b000001100; code_len = 4'd4; end
      4'hE: begin code = 9'b000001101; code_len = 4'd4; end
      4'hF: begin code = 9'b000001110; code_len = 4'd4; end
      4'hC: begin code = 9'b000010111; code_len = 4'd5; end
      4'h3: begin code = 9'b000011110; code_len = 4'd5; end
      4'hB: begin code = 9'b000101101; code_len = 4'd6; end
      4'h4: begin code = 9'b000111111; code_len = 4'd6; end
      4'hA: begin code = 9'b001011000; code_len = 4'd7; end
      4'h6: begin code = 9'b001011001; code_len = 4'd7; end
      4'h5: begin code = 9'b001111101; code_len = 4'd7; end
      4'h9: begin code = 9'b011111000; code_len = 4'd8; end
      4'h8: begin code = 9'b111110010; code_len = 4'd9; end
      4'h7: begin code = 9'b111110011; code_len = 4'd9; end
    endcase
  end

  // New code lands directly below the bits already held.
  logic [BUF_W-1:0] code_ext;
  logic [BUF_W-1:0] code_pos;
  logic [3:0] shamt;
  assign code_ext = BUF_W'(code);
  assign shamt = 4'(BUF_W) - bit_count - code_len;
  assign code_pos = code_ext << shamt;

  logic [3:0] top4;
  logic [3:0] part_data;
  assign top4 = bit_buf[BUF_W-1 -: 4];
  // Tail chunk is right-justified with zeros above it.
  assign part_data = top4 >> (3'd4 - bit_count[2:0]);

  logic slot_free;
  logic full;
  logic part;
  logic accept;
  assign slot_free = !out_valid || out_ready;
  assign full = bit_count >= 4'd4;
  assign part = (state == S_FLUSH) && (bit_count != 4'd0) && !full;
  assign sym_ready = reset_n && !full && !flush_pend;
  assign accept = sym_valid && sym_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_RUN;
      bit_buf    <= '0;
      bit_count  <= '0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_len    <= '0;
    end else begin
      flush_done <= 1'b0;
      if (accept) begin
        bit_buf   <= bit_buf | code_pos;
        bit_count <= bit_count + code_len;
      end
      if (slot_free) begin
        if (full) begin
          out_valid <= 1'b1;
          out_data  <= top4;
          out_len   <= 3'd4;
          bit_buf   <= bit_buf << 4;
          bit_count <= bit_count - 4'd4;
        end else if (part) begin
          out_valid <= 1'b1;
          out_data  <= part_data;
          out_len   <= bit_count[2:0];
          bit_buf   <= '0;
          bit_count <= '0;
        end else begin
          out_valid <= 1'b0;
        end
      end
      case (state)
        S_RUN: begin
          if (flush) begin
            state      <= S_FLUSH;
            flush_pend <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (bit_count == 4'd0 && slot_free) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          flush_done <= 1'b1;
          flush_pend <= 1'b0;
          state      <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule
